id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32 core, with integrated load-use hazard detection.
- Captures decoded operands and control from ID and presents them to EX. Its registered rs1/rs2/rd/RegWrite fields are the ID_EX source indices consumed by the forwarding unit.
- Inserts bubbles on load-use hazards and on EX branch flushes, freezes on external memory stall, and keeps saturating stall/flush event counters.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 8, width of packed control bundle; bit layout comes from the package.
- CNT_W, 16, width of each event counter.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous reset, active-high
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  XLEN  PC of ID instruction
- id_rs1_i / id_rs2_i / id_rd_i  in  5 each  register indices
- id_uses_rs1_i / id_uses_rs2_i  in  1 each  instruction actually reads rs1/rs2
- id_rs1_data_i / id_rs2_data_i  in  XLEN each  register-file read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_ctrl_i  in  CTRL_W  packed control bundle
- ex_flush_i  in  1  taken branch/jump resolved in EX
- ext_stall_i  in  1  memory-side stall; freezes whole pipe
- ex_valid_o  out  1  EX holds a real instruction
- ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN each  registered copies
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5 each  registered indices, feed forwarding unit
- ex_ctrl_o  out  CTRL_W  registered control
- pc_write_o  out  1  PC may advance
- if_id_write_o  out  1  IF/ID register may load
- load_use_stall_o  out  1  load-use hazard bubble inserted this cycle
- stall_cnt_o  out  CNT_W  load-use bubble count
- flush_cnt_o  out  CNT_W  flush bubble count

Behaviour:
- Reset (async, rst_i=1): all registered outputs are 0, including ex_valid_o, ex_ctrl_o, indices and both counters. pc_write_o and if_id_write_o then evaluate to 1 while ext_stall_i=0.
- Hazard (combinational): haz = ex_valid_o & ex_ctrl_o[CTRL_MEMREAD] & (ex_rd_o != 0) & id_valid_i & ((id_uses_rs1_i & id_rs1_i == ex_rd_o) | (id_uses_rs2_i & id_rs2_i == ex_rd_o)).
- load_use_stall_o = haz & ~ex_flush_i & ~ext_stall_i.
- pc_write_o = if_id_write_o = ~ext_stall_i & ~load_use_stall_o.
- Rising-edge update, priority highest first:
  1. ext_stall_i=1: every register holds; counters hold.
  2. ex_flush_i=1: bubble; flush_cnt_o += 1, saturating at all-ones. The flush overrides a simultaneous hazard; stall_cnt_o is not incremented.
  3. load_use_stall_o=1: bubble; stall_cnt_o += 1, saturating.
  4. Otherwise: load all ID fields. ex_valid_o = id_valid_i. If id_valid_i=0, load as a bubble.
- Bubble definition: ex_valid_o=0, ex_ctrl_o=0, ex_rs1_o=ex_rs2_o=ex_rd_o=0. Data, pc and imm are loaded from ID, with don't-care value. Because all indices are 0, the forwarding unit sees no match.
- Latency: 1 cycle ID→EX. A load-use stall always costs exactly 1 bubble. After the bubble the load sits in MEM and the consumer is resolved by forwarding.
- Back-to-back loads with dependent chains each produce one bubble per dependency.
- Reset asserted mid-stall clears the pending bubble. The next instruction is loaded normally after release.

Decomposition:
- Package riscv_pipe_pkg holds:
  - CTRL_W.
  - Control bit indices: CTRL_REGWRITE=0, CTRL_MEMREAD=1, CTRL_MEMWRITE=2, CTRL_MEMTOREG=3, CTRL_ALUSRC=4, CTRL_ALUOP=7:5.
  - A CTRL_BUBBLE constant equal to all-zeros.
- One combinational sub-module, load_use_detect, computes haz. The register/counter logic stays in id_ex_stage.

Test Plan:
- Plain flow: ID add x3,x1,x2 (pc=0x100, ctrl RegWrite) → next cycle ex_valid_o=1, ex_rd_o=3, ex_pc_o=0x100; pc_write_o=1 throughout.
- Load-use: EX holds lw x5 (MemRead=1, rd=5); ID holds add x6,x5,x7 with uses_rs1=1 → load_use_stall_o=1, pc_write_o=0, if_id_write_o=0. Next cycle the bubble has ex_valid_o=0, ex_ctrl_o=0 and ex_rd_o=0, and stall_cnt_o=1. The following cycle add loads with ex_rs1_o=5.
- No false hazard:
  - lw x0 followed by a consumer of x0 → no stall.
  - lw x5 followed by lui x5 (uses_rs1=uses_rs2=0) → no stall.
- Flush over hazard: same setup as load-use, plus ex_flush_i=1 → load_use_stall_o=0 and a bubble is loaded; flush_cnt_o=1, stall_cnt_o unchanged.
- ext_stall_i held 3 cycles during load-use → all outputs frozen and counters unchanged. On release, exactly one bubble is inserted.
- Saturation/reset: with CNT_W=2, run 5 load-use stalls → stall_cnt_o=3. Assert rst_i asynchronously mid-cycle → every output goes to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RV32 pipeline: control-bundle layout and
// register-index helpers used by the ID/EX stage and its hazard logic.
package riscv_pipe_pkg;

    localparam int CTRL_W = 8;

    // Bit positions inside the packed control bundle
    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEMREAD   = 1;
    localparam int CTRL_MEMWRITE  = 2;
    localparam int CTRL_MEMTOREG  = 3;
    localparam int CTRL_ALUSRC    = 4;
    localparam int CTRL_ALUOP_LSB = 5;
    localparam int CTRL_ALUOP_MSB = 7;

    // A bubble carries no side effects: every control bit cleared
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_X0 = 5'd0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX bundle: decoded operands/control from ID and their registered
// copies presented to EX and the forwarding unit.
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = riscv_pipe_pkg::CTRL_W
);
    import riscv_pipe_pkg::*;

    // ID side
    logic              id_valid_i;
    logic [XLEN-1:0]   id_pc_i;
    reg_idx_t          id_rs1_i;
    reg_idx_t          id_rs2_i;
    reg_idx_t          id_rd_i;
    logic              id_uses_rs1_i;
    logic              id_uses_rs2_i;
    logic [XLEN-1:0]   id_rs1_data_i;
    logic [XLEN-1:0]   id_rs2_data_i;
    logic [XLEN-1:0]   id_imm_i;
    logic [CTRL_W-1:0] id_ctrl_i;

    // EX side
    logic              ex_valid_o;
    logic [XLEN-1:0]   ex_pc_o;
    logic [XLEN-1:0]   ex_rs1_data_o;
    logic [XLEN-1:0]   ex_rs2_data_o;
    logic [XLEN-1:0]   ex_imm_o;
    reg_idx_t          ex_rs1_o;
    reg_idx_t          ex_rs2_o;
    reg_idx_t          ex_rd_o;
    logic [CTRL_W-1:0] ex_ctrl_o;

    // Decode stage drives ID fields and observes EX
    modport master (
        output id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_uses_rs1_i, id_uses_rs2_i, id_rs1_data_i, id_rs2_data_i,
               id_imm_i, id_ctrl_i,
        input  ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
               ex_rs1_o, ex_rs2_o, ex_rd_o, ex_ctrl_o
    );

    // Pipeline register consumes ID fields and drives EX
    modport slave (
        input  id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_uses_rs1_i, id_uses_rs2_i, id_rs1_data_i, id_rs2_data_i,
               id_imm_i, id_ctrl_i,
        output ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
               ex_rs1_o, ex_rs2_o, ex_rd_o, ex_ctrl_o
    );

endinterface

// File: rtl/id_ex_stage_load_use.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID. x0 is never a real dependency.
module load_use_detect
    import riscv_pipe_pkg::*;
(
    input  logic     i_ex_valid,
    input  logic     i_ex_memread,
    input  reg_idx_t i_ex_rd,
    input  logic     i_id_valid,
    input  logic     i_id_uses_rs1,
    input  reg_idx_t i_id_rs1,
    input  logic     i_id_uses_rs2,
    input  reg_idx_t i_id_rs2,
    output logic     o_haz
);

    logic w_rs1_match;
    logic w_rs2_match;
    logic w_ex_is_load;

    // Source-operand matches only count when the operand is actually read
    always_comb begin
        w_rs1_match  = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
        w_rs2_match  = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
        w_ex_is_load = i_ex_valid & i_ex_memread & (i_ex_rd != REG_X0);
        o_haz        = w_ex_is_load & i_id_valid & (w_rs1_match | w_rs2_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX-flush bubbles,
// whole-pipe freeze on memory stall and saturating stall/flush counters.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = riscv_pipe_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    id_ex_stage_if.slave      bus,
    input  logic              ex_flush_i,
    input  logic              ext_stall_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              load_use_stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);
    import riscv_pipe_pkg::*;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    reg_idx_t          r_rs1;
    reg_idx_t          r_rs2;
    reg_idx_t          r_rd;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_haz;
    logic              w_bubble;
    logic [CNT_W-1:0]  w_stall_cnt_next;
    logic [CNT_W-1:0]  w_flush_cnt_next;

    load_use_detect u_load_use (
        .i_ex_valid    (r_valid),
        .i_ex_memread  (r_ctrl[CTRL_MEMREAD]),
        .i_ex_rd       (r_rd),
        .i_id_valid    (bus.id_valid_i),
        .i_id_uses_rs1 (bus.id_uses_rs1_i),
        .i_id_rs1      (bus.id_rs1_i),
        .i_id_uses_rs2 (bus.id_uses_rs2_i),
        .i_id_rs2      (bus.id_rs2_i),
        .o_haz         (w_haz)
    );

    // A flush kills the consumer anyway and a memory stall freezes
    // everything, so neither counts as a load-use bubble
    always_comb begin
        load_use_stall_o = w_haz & ~ex_flush_i & ~ext_stall_i;
        pc_write_o       = ~ext_stall_i & ~load_use_stall_o;
        if_id_write_o    = ~ext_stall_i & ~load_use_stall_o;
        w_bubble         = ex_flush_i | load_use_stall_o | ~bus.id_valid_i;
        w_stall_cnt_next = (r_stall_cnt == '1) ? r_stall_cnt : r_stall_cnt + 1'b1;
        w_flush_cnt_next = (r_flush_cnt == '1) ? r_flush_cnt : r_flush_cnt + 1'b1;
    end

    // Pipeline register: freeze > flush bubble > load-use bubble > load
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rs1       <= REG_X0;
            r_rs2       <= REG_X0;
            r_rd        <= REG_X0;
            r_ctrl      <= CTRL_BUBBLE;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!ext_stall_i) begin
            // Payload follows ID unconditionally; it is don't-care in a bubble
            r_pc       <= bus.id_pc_i;
            r_rs1_data <= bus.id_rs1_data_i;
            r_rs2_data <= bus.id_rs2_data_i;
            r_imm      <= bus.id_imm_i;
            if (w_bubble) begin
                // Zeroed indices keep the forwarding unit from matching
                r_valid <= 1'b0;
                r_rs1   <= REG_X0;
                r_rs2   <= REG_X0;
                r_rd    <= REG_X0;
                r_ctrl  <= CTRL_BUBBLE;
            end else begin
                r_valid <= 1'b1;
                r_rs1   <= bus.id_rs1_i;
                r_rs2   <= bus.id_rs2_i;
                r_rd    <= bus.id_rd_i;
                r_ctrl  <= bus.id_ctrl_i;
            end
            if (ex_flush_i) begin
                r_flush_cnt <= w_flush_cnt_next;
            end else if (load_use_stall_o) begin
                r_stall_cnt <= w_stall_cnt_next;
            end
        end
    end

    always_comb begin
        bus.ex_valid_o    = r_valid;
        bus.ex_pc_o       = r_pc;
        bus.ex_rs1_data_o = r_rs1_data;
        bus.ex_rs2_data_o = r_rs2_data;
        bus.ex_imm_o      = r_imm;
        bus.ex_rs1_o      = r_rs1;
        bus.ex_rs2_o      = r_rs2;
        bus.ex_rd_o       = r_rd;
        bus.ex_ctrl_o     = r_ctrl;
        stall_cnt_o       = r_stall_cnt;
        flush_cnt_o       = r_flush_cnt;
    end

endmodule
